// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the register-file bus sequencer:
//   - FSM state encoding (IDLE, DRIVE, LATCH, DONE)
//   - onehot(): index -> one-hot select vector
// No ports (package).
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Widest select vector onehot() can produce; callers cast down to NREG bits.
  localparam int ONEHOT_MAX = 64;

  // Indices at or beyond ONEHOT_MAX yield all zeros.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
    return ONEHOT_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/idx_decoder.sv
// -----------------------------------------------------------------------------
// idx_decoder
// Decodes a register index into a one-hot select line, gated by an enable.
// Ports:
//   i_idx     in   IDXW  register index
//   i_en      in   1     1 = drive the decoded line, 0 = all lines low
//   o_onehot  out  NREG  one-hot (or zero) select vector
// -----------------------------------------------------------------------------
module idx_decoder #(
  parameter int IDXW = 3,
  parameter int NREG = 8
) (
  input  logic [IDXW-1:0] i_idx,
  input  logic            i_en,
  output logic [NREG-1:0] o_onehot
);
  import bus_pkg::*;

  assign o_onehot = i_en ? NREG'(onehot(32'(i_idx))) : '0;

endmodule

// File: rtl/bus_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_transfer_ctrl
// Sequencer for the shared tri-state register bus. Accepts a transfer request,
// enables the source register onto the bus for SETTLE cycles plus one latch
// cycle, samples the bus, optionally strobes the destination register's set
// line during the latch cycle, then reports the sampled value.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req_valid  in   1      transfer request present
//   req_ready  out  1      idle / finishing, can accept a request
//   req_src    in   IDXW   source register index
//   req_dst    in   IDXW   destination register index
//   req_wr     in   1      1 = copy src->dst, 0 = read src only
//   bus_in     in   WIDTH  shared bus as seen by this block
//   en_out     out  NREG   one-hot source output enables
//   set_out    out  NREG   one-hot destination set strobes
//   rd_data    out  WIDTH  last value sampled from the bus
//   rd_valid   out  1      one-cycle pulse, rd_data updated
//   err        out  1      one-cycle pulse, request rejected
// -----------------------------------------------------------------------------
module bus_transfer_ctrl
  import bus_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NREG   = 8,
  parameter int IDXW   = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDXW-1:0]  req_src,
  input  logic [IDXW-1:0]  req_dst,
  input  logic             req_wr,
  input  logic [WIDTH-1:0] bus_in,
  output logic [NREG-1:0]  en_out,
  output logic [NREG-1:0]  set_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             err
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [IDXW-1:0]  r_src;
  logic [IDXW-1:0]  r_dst;
  logic             r_wr;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_err;

  logic w_accept;
  logic w_reject;
  logic w_en_active;
  logic w_set_active;

  // DONE also accepts so a request held high chains with no idle bubble.
  assign req_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept  = req_valid && req_ready;
  assign w_reject  = (32'(req_src) >= NREG) ||
                     (req_wr && ((32'(req_dst) >= NREG) || (req_src == req_dst)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_wr      <= 1'b0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept && w_reject) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_src   <= req_src;
            r_dst   <= req_dst;
            r_wr    <= req_wr;
            r_cnt   <= SETTLE_LOAD;
            r_state <= ST_DRIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == '0) r_state <= ST_LATCH;
          else             r_cnt   <= r_cnt - 4'd1;
        end
        ST_LATCH: begin
          r_rd_data <= bus_in;
          r_state   <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the state register rather than registered
  // themselves, so an asynchronous reset drops them at once.
  assign w_en_active  = (r_state == ST_DRIVE) || (r_state == ST_LATCH);
  assign w_set_active = (r_state == ST_LATCH) && r_wr;

  idx_decoder #(.IDXW(IDXW), .NREG(NREG)) u_en_dec (
    .i_idx    (r_src),
    .i_en     (w_en_active),
    .o_onehot (en_out)
  );

  idx_decoder #(.IDXW(IDXW), .NREG(NREG)) u_set_dec (
    .i_idx    (r_dst),
    .i_en     (w_set_active),
    .o_onehot (set_out)
  );

  assign rd_data  = r_rd_data;
  assign rd_valid = (r_state == ST_DONE);
  assign err      = r_err;

endmodule
